mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_rr_arbiter.sv | 28 ++
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus types for the memory arbiter: command bus layout, mode codes and the idle command.
package BusTypes;

  typedef enum logic [1:0] {
    MODE_READ    = 2'b00,
    MODE_WRITE   = 2'b01,
    MODE_ALLOC   = 2'b10,
    MODE_SETZERO = 2'b11
  } mem_mode_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] offset;
    logic [31:0] data;
    mem_mode_t   mode;
  } mem_in_bus_t;

  typedef enum logic {
    ST_ISSUE,
    ST_DRAIN
  } arb_state_t;

  localparam mem_in_bus_t IDLE_CMD = '{address: 32'd0, offset: 32'd0, data: 32'd0, mode: MODE_READ};

  // Only read and alloc produce a data word one cycle after issue.
  function automatic logic returns_data(mem_mode_t mode);
    return (mode == MODE_READ) || (mode == MODE_ALLOC);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin selector: grants the first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that forwards one requester's command per cycle to mem_sys and
// routes the single-cycle-latency read/alloc response back to the issuing requester.
module mem_arbiter
  import BusTypes::*;
#(
  parameter int NREQ = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  mem_in_bus_t [NREQ-1:0] req_bus,
  output logic [NREQ-1:0]        req_ready,
  output mem_in_bus_t            mem_bus,
  input  logic [31:0]            mem_data_out,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [31:0]            rsp_data
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state_q;
  logic [PTR_W-1:0] ptr_q;
  logic             tag_valid_q;
  logic [PTR_W-1:0] tag_idx_q;

  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] win_idx;
  logic             any_grant;

  // Reset and DRAIN both mask every request, which also forces the idle command.
  assign arb_req = (state_q == ST_ISSUE && !reset) ? req_valid : '0;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (arb_req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) win_idx = PTR_W'(k);
    end
  end

  assign any_grant = |grant;
  assign req_ready = grant;
  assign mem_bus   = any_grant ? req_bus[win_idx] : IDLE_CMD;
  assign rsp_data  = mem_data_out;

  // The tag is gated by reset so a response in flight when reset rises never appears.
  always_comb begin
    rsp_valid = '0;
    if (tag_valid_q && !reset) rsp_valid[tag_idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ISSUE;
      ptr_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_idx_q   <= '0;
    end else begin
      tag_valid_q <= any_grant && returns_data(mem_bus.mode);
      tag_idx_q   <= win_idx;
      case (state_q)
        ST_ISSUE: begin
          if (any_grant) begin
            ptr_q <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            if (mem_bus.mode == MODE_SETZERO) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: state_q <= ST_ISSUE;
        default:  state_q <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural mem_sys and reference model.
module tb_mem_arbiter;
  import BusTypes::*;

  localparam int NREQ = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  mem_in_bus_t [NREQ-1:0] req_bus;
  logic [NREQ-1:0]        req_ready;
  mem_in_bus_t            mem_bus;
  logic [31:0]            mem_data_out = 32'd0;
  logic [NREQ-1:0]        rsp_valid;
  logic [31:0]            rsp_data;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct {
    int          stamp;
    int          idx;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  mem_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_bus      (req_bus),
    .req_ready    (req_ready),
    .mem_bus      (mem_bus),
    .mem_data_out (mem_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural mem_sys: registered data_out, word-addressed store, bump allocator.
  logic [31:0] sys_words [logic [31:0]];
  logic [31:0] sys_heap = 32'h1000;
  always @(posedge clk) begin
    logic [31:0] a;
    a = mem_bus.address + mem_bus.offset;
    case (mem_bus.mode)
      MODE_READ:  mem_data_out <= sys_words.exists(a) ? sys_words[a] : 32'd0;
      MODE_WRITE: sys_words[a] = mem_bus.data;
      MODE_ALLOC: begin
        mem_data_out <= sys_heap;
        sys_heap = sys_heap + mem_bus.offset;
      end
      default: for (int i = 0; i < 16; i++) if (i < mem_bus.offset) sys_words[mem_bus.address + i] = 32'd0;
    endcase
  end

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
  endtask

  // Reference model: round-robin pointer, one-cycle drain flag and an ideal memory.
  logic [31:0] ref_words [logic [31:0]];
  logic [31:0] ref_heap  = 32'h1000;
  int          ref_ptr   = 0;
  bit          ref_drain = 1'b0;

  always @(negedge clk) begin
    int              w;
    int              j;
    logic [NREQ-1:0] exp_ready;
    mem_in_bus_t     exp_bus;
    logic [31:0]     a;
    w = -1;
    if (!reset && !ref_drain) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (ref_ptr + k) % NREQ;
        if (w < 0 && req_valid[j]) w = j;
      end
    end
    exp_ready = '0;
    exp_bus   = IDLE_CMD;
    if (w >= 0) begin
      exp_ready[w] = 1'b1;
      exp_bus      = req_bus[w];
    end
    check_output("req_ready", req_ready, exp_ready);
    check_output("mem_bus", mem_bus, exp_bus);
    if (w >= 0) begin
      a = exp_bus.address + exp_bus.offset;
      case (exp_bus.mode)
        MODE_READ:  exp_q.push_back('{cyc + 1, w, ref_words.exists(a) ? ref_words[a] : 32'd0});
        MODE_WRITE: ref_words[a] = exp_bus.data;
        MODE_ALLOC: begin
          exp_q.push_back('{cyc + 1, w, ref_heap});
          ref_heap = ref_heap + exp_bus.offset;
        end
        default: for (int i = 0; i < 16; i++) if (i < exp_bus.offset) ref_words[exp_bus.address + i] = 32'd0;
      endcase
    end
    if (reset) begin
      ref_ptr   = 0;
      ref_drain = 1'b0;
    end else if (w >= 0) begin
      ref_ptr   = (w + 1) % NREQ;
      ref_drain = (exp_bus.mode == MODE_SETZERO);
    end else begin
      ref_drain = 1'b0;
    end
  end

  // Response monitor: a response due this cycle is dropped if reset is high.
  always @(negedge clk) begin
    exp_t            e;
    logic [NREQ-1:0] exp_v;
    bit              due;
    due = (exp_q.size() > 0) && (exp_q[0].stamp == cyc);
    if (reset) begin
      if (due) void'(exp_q.pop_front());
      check_output("rsp_valid_in_reset", rsp_valid, '0);
    end else if (due) begin
      e = exp_q.pop_front();
      exp_v = '0;
      exp_v[e.idx] = 1'b1;
      check_output("rsp_valid", rsp_valid, exp_v);
      check_output("rsp_data", rsp_data, e.data);
    end else begin
      check_output("rsp_valid_idle", rsp_valid, '0);
    end
  end

  function automatic mem_in_bus_t mk(input mem_mode_t mode, input logic [31:0] addr,
                                     input logic [31:0] off, input logic [31:0] data);
    mem_in_bus_t b;
    b.address = addr;
    b.offset  = off;
    b.data    = data;
    b.mode    = mode;
    return b;
  endfunction

  task automatic apply_stimulus(input logic rst, input logic [NREQ-1:0] v,
                                input mem_in_bus_t b0, input mem_in_bus_t b1);
    @(posedge clk);
    #1;
    reset      = rst;
    req_valid  = v;
    req_bus[0] = b0;
    req_bus[1] = b1;
  endtask

  function automatic mem_in_bus_t rand_bus();
    mem_mode_t m;
    logic [31:0] off;
    m = mem_mode_t'($urandom_range(0, 3));
    case (m)
      MODE_ALLOC:   off = $urandom_range(1, 16);
      MODE_SETZERO: off = $urandom_range(1, 4);
      default:      off = $urandom_range(0, 3);
    endcase
    return mk(m, $urandom_range(0, 15), off, $urandom);
  endfunction

  initial begin
    mem_in_bus_t rd0;
    mem_in_bus_t rd1;
    reset     = 1'b1;
    req_valid = '0;
    req_bus   = '0;
    rd0 = mk(MODE_READ, 32'h0, 32'h0, 32'h0);
    rd1 = mk(MODE_READ, 32'h1, 32'h0, 32'h0);

    repeat (3) apply_stimulus(1'b1, 2'b11, rd0, rd1);
    repeat (6) apply_stimulus(1'b0, 2'b11, rd0, rd1);

    apply_stimulus(1'b0, 2'b10, rd0, mk(MODE_WRITE, 32'h10, 32'h0, 32'hDEADBEEF));
    apply_stimulus(1'b0, 2'b01, mk(MODE_READ, 32'h10, 32'h0, 32'h0), rd1);

    apply_stimulus(1'b0, 2'b11, mk(MODE_SETZERO, 32'h10, 32'h2, 32'h0), rd1);
    repeat (3) apply_stimulus(1'b0, 2'b11, mk(MODE_READ, 32'h10, 32'h0, 32'h0), rd1);

    apply_stimulus(1'b0, 2'b01, mk(MODE_ALLOC, 32'h0, 32'h8, 32'h0), rd1);
    apply_stimulus(1'b0, 2'b01, mk(MODE_ALLOC, 32'h0, 32'h4, 32'h0), rd1);

    apply_stimulus(1'b0, 2'b01, rd0, rd1);
    repeat (2) apply_stimulus(1'b1, 2'b11, rd0, rd1);
    apply_stimulus(1'b0, 2'b10, rd0, mk(MODE_SETZERO, 32'h4, 32'h1, 32'h0));
    apply_stimulus(1'b1, 2'b11, rd0, rd1);
    apply_stimulus(1'b0, 2'b11, rd0, rd1);

    apply_stimulus(1'b0, 2'b10, rd0, rd1);
    repeat (5) apply_stimulus(1'b0, 2'b00, rd0, rd1);
    apply_stimulus(1'b0, 2'b11, rd0, rd1);

    for (int n = 0; n < 1500; n++) begin
      apply_stimulus(($urandom_range(0, 99) == 0), NREQ'($urandom), rand_bus(), rand_bus());
    end

    repeat (3) apply_stimulus(1'b0, 2'b00, rd0, rd1);
    @(negedge clk);
    #1;
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
